// File: rtl/player_bullet_if.sv
// Bus between the player bullet and its environment: video timing, controls and
// the per-pixel kill outputs. state_o exposes the bullet FSM for observation.
interface player_bullet_if;
  logic       frame_i;
  logic [9:0] sx_i;
  logic [9:0] sy_i;
  logic       de_i;
  logic       fire_i;
  logic [9:0] player_x_i;
  logic       enemy_pixel_i;

  logic       bullet_area_o;
  logic       flying_o;
  logic [3:0] bullet_r_o;
  logic [3:0] bullet_g_o;
  logic [3:0] bullet_b_o;
  logic [9:0] bullet_x_o;
  logic [9:0] bullet_y_o;
  logic [7:0] shots_o;
  logic [7:0] hits_o;
  logic [1:0] state_o;

  // Kill handshake: an enemy is hit in the one cycle where bullet_area_o,
  // flying_o, enemy_pixel_i and de_i are all high; the bullet retires on the
  // following edge, so no second cycle of that shot can ever qualify.
  modport master (
    output frame_i, sx_i, sy_i, de_i, fire_i, player_x_i, enemy_pixel_i,
    input  bullet_area_o, flying_o, bullet_r_o, bullet_g_o, bullet_b_o,
           bullet_x_o, bullet_y_o, shots_o, hits_o, state_o
  );

  modport slave (
    input  frame_i, sx_i, sy_i, de_i, fire_i, player_x_i, enemy_pixel_i,
    output bullet_area_o, flying_o, bullet_r_o, bullet_g_o, bullet_b_o,
           bullet_x_o, bullet_y_o, shots_o, hits_o, state_o
  );
endinterface

// File: rtl/player_bullet.sv
// Player projectile: launches from the ship nose on a fire edge, climbs once per
// frame, retires on a pixel hit or at the screen top, then cools down for frames.
module player_bullet #(
  parameter logic [11:0] COLOR_P    = 12'hFF0,
  parameter int          BULLET_W_P = 4,
  parameter int          BULLET_H_P = 12,
  parameter int          SPEED_P    = 8,
  parameter int          PLAYER_Y_P = 440,
  parameter int          PLAYER_W_P = 40,
  parameter int          COOLDOWN_P = 4
) (
  input logic            clk_i,
  input logic            reset_i,
  player_bullet_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, FLYING = 2'd2, COOLDOWN = 2'd3} state_t;

  localparam int          CD_W    = (COOLDOWN_P > 1) ? $clog2(COOLDOWN_P) : 1;
  localparam logic [10:0] X_MAX   = 11'(640 - BULLET_W_P);
  localparam logic [10:0] NOSE_OF = 11'(PLAYER_W_P / 2 - BULLET_W_P / 2);

  state_t          state;
  logic            fire_q;
  logic [9:0]      bx;
  logic [9:0]      by;
  logic [7:0]      shots;
  logic [7:0]      hits;
  logic [CD_W-1:0] cd;

  logic        fire_re;
  logic [10:0] nose;
  logic [9:0]  launch_x;
  logic [10:0] sx11, sy11, bx11, by11;
  logic        in_x, in_y;
  logic        flying;
  logic        area;
  logic        hit;

  assign fire_re  = bus.fire_i & ~fire_q;
  assign nose     = {1'b0, bus.player_x_i} + NOSE_OF;
  assign launch_x = (nose > X_MAX) ? X_MAX[9:0] : nose[9:0];

  assign sx11   = {1'b0, bus.sx_i};
  assign sy11   = {1'b0, bus.sy_i};
  assign bx11   = {1'b0, bx};
  assign by11   = {1'b0, by};
  assign in_x   = (sx11 >= bx11) && (sx11 < bx11 + 11'(BULLET_W_P));
  assign in_y   = (sy11 >= by11) && (sy11 < by11 + 11'(BULLET_H_P));
  assign flying = (state == FLYING);
  assign area   = flying & in_x & in_y;
  assign hit    = area & bus.enemy_pixel_i & bus.de_i;

  // fire_q resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= IDLE;
      fire_q <= 1'b1;
      bx     <= '0;
      by     <= '0;
      shots  <= '0;
      hits   <= '0;
      cd     <= '0;
    end else begin
      fire_q <= bus.fire_i;
      case (state)
        IDLE: begin
          if (fire_re) state <= ARMED;
        end
        ARMED: begin
          if (bus.frame_i) begin
            bx    <= launch_x;
            by    <= 10'(PLAYER_Y_P - BULLET_H_P);
            shots <= shots + 8'd1;
            state <= FLYING;
          end
        end
        FLYING: begin
          // A hit outranks a simultaneous frame pulse: the position stays frozen.
          if (hit) begin
            hits  <= hits + 8'd1;
            cd    <= CD_W'(COOLDOWN_P - 1);
            state <= COOLDOWN;
          end else if (bus.frame_i) begin
            if (by < 10'(SPEED_P)) begin
              cd    <= CD_W'(COOLDOWN_P - 1);
              state <= COOLDOWN;
            end else begin
              by <= by - 10'(SPEED_P);
            end
          end
        end
        COOLDOWN: begin
          if (bus.frame_i) begin
            if (cd == '0) state <= IDLE;
            else          cd    <= cd - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bullet_area_o = area;
  assign bus.flying_o      = flying;
  assign bus.bullet_r_o    = area ? COLOR_P[11:8] : 4'd0;
  assign bus.bullet_g_o    = area ? COLOR_P[7:4]  : 4'd0;
  assign bus.bullet_b_o    = area ? COLOR_P[3:0]  : 4'd0;
  assign bus.bullet_x_o    = bx;
  assign bus.bullet_y_o    = by;
  assign bus.shots_o       = shots;
  assign bus.hits_o        = hits;
  assign bus.state_o       = state;

endmodule

// File: tb/tb_player_bullet.sv
// Self-checking bench for player_bullet: frame-by-frame scoreboard of position,
// counters and state, plus pixel scans for hit, clamp and reset behaviour.
module tb_player_bullet;

  localparam int W = 39;  // {state[2], fly, bx[10], by[10], shots[8], hits[8]}
  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_FLY = 2'd2, S_CD = 2'd3;

  logic clk;
  logic rst;
  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  player_bullet_if bus ();

  player_bullet dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    bus.frame_i = 1'b1;
    tick();
    bus.frame_i = 1'b0;
  endtask

  task automatic fire_press();
    bus.fire_i = 1'b0;
    tick();
    bus.fire_i = 1'b1;
    tick();
  endtask

  task automatic push(input logic [1:0] st, input logic fly, input logic [9:0] x,
                      input logic [9:0] y, input logic [7:0] sh, input logic [7:0] hi);
    exp_q.push_back({st, fly, x, y, sh, hi});
  endtask

  // scoreboard pop / compare
  task automatic sb_check(input string tag);
    logic [W-1:0] e;
    chk({tag, ".q"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, ".st"},  64'(bus.state_o),    64'(e[38:37]));
      chk({tag, ".fly"}, 64'(bus.flying_o),   64'(e[36]));
      chk({tag, ".x"},   64'(bus.bullet_x_o), 64'(e[35:26]));
      chk({tag, ".y"},   64'(bus.bullet_y_o), 64'(e[25:16]));
      chk({tag, ".sh"},  64'(bus.shots_o),    64'(e[15:8]));
      chk({tag, ".hi"},  64'(bus.hits_o),     64'(e[7:0]));
    end
  endtask

  initial begin
    int ovl, hx, hy, acnt, afirst;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.frame_i = 1'b0;
    bus.sx_i = '0;
    bus.sy_i = '0;
    bus.de_i = 1'b0;
    bus.fire_i = 1'b1;
    bus.player_x_i = 10'd100;
    bus.enemy_pixel_i = 1'b0;
    repeat (3) tick();

    // reset values while reset is held
    push(S_IDLE, 1'b0, 10'd0, 10'd0, 8'd0, 8'd0);
    sb_check("rst");
    chk("rst.area", 64'(bus.bullet_area_o), 64'd0);
    chk("rst.r", 64'(bus.bullet_r_o), 64'd0);
    rst = 1'b0;
    tick();

    // fire held through reset release: no launch
    for (int i = 0; i < 3; i++) begin
      push(S_IDLE, 1'b0, 10'd0, 10'd0, 8'd0, 8'd0);
      frame_pulse();
      sb_check("held");
    end

    // launch at player_x=100, then climb to the top without enemies
    fire_press();
    push(S_ARMED, 1'b0, 10'd0, 10'd0, 8'd0, 8'd0);
    sb_check("armed");
    push(S_FLY, 1'b1, 10'd118, 10'd428, 8'd1, 8'd0);
    frame_pulse();
    sb_check("launch");
    for (int k = 1; k <= 53; k++) begin
      push(S_FLY, 1'b1, 10'd118, 10'(428 - 8 * k), 8'd1, 8'd0);
      frame_pulse();
      sb_check($sformatf("climb%0d", k));
    end
    push(S_CD, 1'b0, 10'd118, 10'd4, 8'd1, 8'd0);
    frame_pulse();
    sb_check("top");
    fire_press();  // dropped in cooldown
    for (int i = 1; i <= 4; i++) begin
      push((i == 4) ? S_IDLE : S_CD, 1'b0, 10'd118, 10'd4, 8'd1, 8'd0);
      frame_pulse();
      sb_check($sformatf("cd%0d", i));
    end
    push(S_IDLE, 1'b0, 10'd118, 10'd4, 8'd1, 8'd0);
    frame_pulse();
    sb_check("nolaunch");

    // hit against enemy box x 100..139, y 300..339
    fire_press();
    push(S_FLY, 1'b1, 10'd118, 10'd428, 8'd2, 8'd0);
    frame_pulse();
    sb_check("launch2");
    for (int k = 1; k <= 12; k++) frame_pulse();
    ovl = 0;
    hx = -1;
    hy = -1;
    for (int y = 300; y <= 339; y++) begin
      for (int x = 100; x <= 139; x++) begin
        bus.sx_i = 10'(x);
        bus.sy_i = 10'(y);
        bus.de_i = 1'b1;
        bus.enemy_pixel_i = 1'b1;
        #1;
        if (bus.bullet_area_o && bus.enemy_pixel_i) begin
          if (ovl == 0) begin
            hx = x;
            hy = y;
          end
          ovl++;
        end
        @(posedge clk);
        #1;
      end
    end
    bus.de_i = 1'b0;
    bus.enemy_pixel_i = 1'b0;
    chk("hit.ovl", 64'(ovl), 64'd1);
    chk("hit.px", 64'(hx), 64'd118);
    chk("hit.py", 64'(hy), 64'd332);
    push(S_CD, 1'b0, 10'd118, 10'd332, 8'd2, 8'd1);
    sb_check("hit");
    for (int i = 0; i < 4; i++) frame_pulse();
    push(S_IDLE, 1'b0, 10'd118, 10'd332, 8'd2, 8'd1);
    sb_check("hit.idle");

    // right-edge clamp at player_x=630
    fire_press();
    bus.player_x_i = 10'd630;
    push(S_FLY, 1'b1, 10'd636, 10'd428, 8'd3, 8'd1);
    frame_pulse();
    sb_check("clamp");
    acnt = 0;
    afirst = -1;
    bus.sy_i = 10'd430;
    for (int x = 630; x <= 645; x++) begin
      bus.sx_i = 10'(x);
      #1;
      if (bus.bullet_area_o) begin
        if (acnt == 0) afirst = x;
        acnt++;
      end
      tick();
    end
    chk("clamp.cnt", 64'(acnt), 64'd4);
    chk("clamp.first", 64'(afirst), 64'd636);
    bus.sx_i = 10'd637;
    #1;
    chk("col.area", 64'(bus.bullet_area_o), 64'd1);
    chk("col.rgb", 64'({bus.bullet_r_o, bus.bullet_g_o, bus.bullet_b_o}), 64'h000000000000FF0);

    // reset mid-flight: outputs drop without waiting for a clock edge
    rst = 1'b1;
    #1;
    chk("mrst.area", 64'(bus.bullet_area_o), 64'd0);
    chk("mrst.rgb", 64'({bus.bullet_r_o, bus.bullet_g_o, bus.bullet_b_o}), 64'd0);
    push(S_IDLE, 1'b0, 10'd0, 10'd0, 8'd0, 8'd0);
    sb_check("mrst");
    tick();
    rst = 1'b0;
    tick();
    push(S_IDLE, 1'b0, 10'd0, 10'd0, 8'd0, 8'd0);
    frame_pulse();
    sb_check("mrst.held");

    // hit in the same cycle as frame_i: hit wins, no move
    bus.player_x_i = 10'd100;
    fire_press();
    push(S_FLY, 1'b1, 10'd118, 10'd428, 8'd1, 8'd0);
    frame_pulse();
    sb_check("launch3");
    for (int k = 1; k <= 12; k++) frame_pulse();
    bus.sx_i = 10'd118;
    bus.sy_i = 10'd332;
    bus.de_i = 1'b1;
    bus.enemy_pixel_i = 1'b1;
    push(S_CD, 1'b0, 10'd118, 10'd332, 8'd1, 8'd1);
    frame_pulse();
    bus.de_i = 1'b0;
    bus.enemy_pixel_i = 1'b0;
    sb_check("hitframe");
    push(S_CD, 1'b0, 10'd118, 10'd332, 8'd1, 8'd1);
    frame_pulse();
    sb_check("hitframe.after");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/player_bullet.md
Name: player_bullet

Overview:
- Player projectile for the enemy field, directly upstream of the enemy tiles.
- Accepts a fire request and launches one bullet from the player ship's nose. Moves it up once per frame.
- Drives the per-pixel bullet_area_o / flying_o pair that every enemy tile samples for kill detection.
- Retires on a pixel-coincident hit or on reaching the screen top, then enforces a frame-based cooldown before the next shot.

Parameters:
- COLOR_P, 12'hFF0, bullet RGB {r,g,b}.
- BULLET_W_P, 4, bullet width in pixels.
- BULLET_H_P, 12, bullet height in pixels.
- SPEED_P, 8, upward pixels per frame.
- PLAYER_Y_P, 440, top row of the player ship.
- PLAYER_W_P, 40, player ship width.
- COOLDOWN_P, 4, frames spent in COOLDOWN after retire (>=1).

Ports:
- clk_i  in  1  pixel clock.
- reset_i  in  1  asynchronous, active-high reset; one clock.
- frame_i  in  1  one-cycle pulse at start of vertical blank.
- sx_i  in  10  current pixel x.
- sy_i  in  10  current pixel y.
- de_i  in  1  display enable.
- fire_i  in  1  synchronized fire button, level.
- player_x_i  in  10  player ship left x.
- enemy_pixel_i  in  1  OR of draw_enemy over live (not dead) enemies.
- bullet_area_o  out  1  current pixel is inside the bullet rectangle while flying.
- flying_o  out  1  state == FLYING.
- bullet_r_o  out  4  red colour output.
- bullet_g_o  out  4  green colour output.
- bullet_b_o  out  4  blue colour output.
- bullet_x_o  out  10  bullet left x.
- bullet_y_o  out  10  bullet top y.
- shots_o  out  8  launches since reset, wraps.
- hits_o  out  8  hits since reset, wraps.

Behaviour:
- Reset (async) values:
  - state = IDLE.
  - bullet_x_o = 0, bullet_y_o = 0.
  - shots_o = 0, hits_o = 0.
  - cooldown counter = 0.
  - fire edge register = 1 (prevents a held button firing out of reset).
  - All outputs therefore 0.
- Fire edge: fire_re = fire_i & ~fire_q, where fire_q is registered each cycle.
- States: IDLE, ARMED, FLYING, COOLDOWN.
- IDLE:
  - fire_re -> ARMED.
  - fire_re in any other state is dropped, not queued.
- ARMED: on frame_i:
  - bullet_x = min(player_x_i + PLAYER_W_P/2 - BULLET_W_P/2, 640 - BULLET_W_P), computed in 11 bits.
  - bullet_y = PLAYER_Y_P - BULLET_H_P.
  - shots_o += 1.
  - -> FLYING.
  - player_x_i is sampled only at this instant.
- FLYING, evaluated in priority order:
  1. Hit: bullet_area_o & enemy_pixel_i & de_i in a cycle. Next edge -> COOLDOWN, hits_o += 1, position frozen.
  2. Else on frame_i with bullet_y < SPEED_P (miss at top) -> COOLDOWN.
  3. Else on frame_i: bullet_y -= SPEED_P.
- COOLDOWN:
  - Counter loads COOLDOWN_P - 1 on entry.
  - Decrements on each frame_i.
  - frame_i with counter == 0 -> IDLE.
- Combinational outputs:
  - bullet_area_o = flying_o & sx_i in [bx, bx+BULLET_W_P) & sy_i in [by, by+BULLET_H_P). Comparisons are 11-bit.
  - flying_o is registered state decode, with zero latency to bullet_area_o.
  - Colour = COLOR_P when bullet_area_o, else 0.
- Kill handshake: on a hit cycle, bullet_area_o and flying_o are both high in the same cycle the enemy samples them. Exactly one flying cycle overlaps the first colliding pixel. The bullet is gone from the next cycle on, so at most one enemy per shot is killed; further overlapping pixels of the same shot are ignored.
- Frame alignment: position changes only on frame_i, so the drawn image is stable within a frame.
- Simultaneous events:
  - Hit and frame_i in the same cycle: hit wins, no move.
  - fire_re in the cycle COOLDOWN exits: dropped.
- Reset mid-flight: immediate IDLE, and bullet_area_o drops asynchronously.

Test Plan:
- Reset, fire_i pulse 0->1, player_x_i=100, one frame_i -> flying_o=1, bullet_x_o=118, bullet_y_o=428, shots_o=1. Next frame_i -> bullet_y_o=420.
- No enemies, launched as above -> 53 frames after launch bullet_y_o=4. Next frame_i -> flying_o=0 (COOLDOWN). 4 more frame_i -> IDLE. fire_re during COOLDOWN produces no launch.
- Enemy box x 100..139, y 300..339, drive enemy_pixel_i from it -> one cycle with bullet_area_o & enemy_pixel_i. Next cycle flying_o=0, hits_o=1, bullet_y_o unchanged.
- player_x_i=630 at launch -> bullet_x_o=636 (clamped). bullet_area_o asserted only for sx_i 636..639.
- fire_i held high through reset release -> no launch until a new 0->1 edge. Assert reset_i mid-flight -> all outputs 0 immediately.
- Hit coinciding with frame_i -> COOLDOWN, bullet_y_o not decremented, hits_o incremented once.
